// File: rtl/data_ram_mmio_pkg.sv
// Shared decode constants and UART state encoding
// for the data-side RAM/MMIO block.
package data_ram_mmio_pkg;

   localparam logic [3:0] MEM_REGION_RAM = 4'h0;
   localparam logic [3:0] MEM_REGION_IO  = 4'h1;

   localparam logic [3:0] IO_LED       = 4'h0;
   localparam logic [3:0] IO_CYCLE     = 4'h4;
   localparam logic [3:0] IO_UART_TX   = 4'h8;
   localparam logic [3:0] IO_UART_STAT = 4'hC;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/data_ram_mmio_uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits
// LSB first, one stop bit; registered outputs.
module uart_tx
   import data_ram_mmio_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [7:0] byte_i,
   output logic       busy_o,
   output logic       tx_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   uart_state_e state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          last;

   assign last = (cnt == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= UART_IDLE;
         cnt    <= '0;
         idx    <= '0;
         shreg  <= '0;
         tx_o   <= 1'b1;
         busy_o <= 1'b0;
      end else begin
         case (state)
            UART_IDLE: begin
               if (start_i) begin
                  shreg  <= byte_i;
                  state  <= UART_START;
                  tx_o   <= 1'b0;
                  busy_o <= 1'b1;
                  cnt    <= '0;
               end
            end
            UART_START: begin
               if (last) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= UART_DATA;
                  tx_o  <= shreg[0];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            UART_DATA: begin
               if (last) begin
                  cnt <= '0;
                  if (idx == 3'd7) begin
                     state <= UART_STOP;
                     tx_o  <= 1'b1;
                  end else begin
                     // shift so the next bit always sits at [1]
                     idx   <= idx + 1'b1;
                     shreg <= shreg >> 1;
                     tx_o  <= shreg[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            UART_STOP: begin
               if (last) begin
                  cnt    <= '0;
                  state  <= UART_IDLE;
                  busy_o <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state  <= UART_IDLE;
               tx_o   <= 1'b1;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/data_ram_mmio.sv
// Data RAM with byte-lane writes plus an MMIO window
// holding LED, cycle counter and UART transmitter.
module data_ram_mmio
  import data_ram_mmio_pkg::*;
#(
  parameter int    RAM_AW       = 12,
  parameter int    CLKS_PER_BIT = 868,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [7:0]  led_o,
  output logic        uart_tx_o
);

  logic [31:0] mem [2**RAM_AW];

  logic [3:0]        region;
  logic [3:0]        off;
  logic [RAM_AW-1:0] widx;
  logic              is_ram;
  logic              is_io;
  logic              ram_we;
  logic              io_we;
  logic              uart_start;
  logic              uart_busy;
  logic [7:0]        led_q;
  logic [31:0]       cycle_q;
  logic              unused_ok;

  assign region = addr_i[31:28];
  assign off    = addr_i[3:0];
  assign widx   = addr_i[RAM_AW+1:2];
  assign is_ram = (region == MEM_REGION_RAM);
  assign is_io  = (region == MEM_REGION_IO);
  assign ram_we = ce_i & we_i & is_ram;
  assign io_we  = ce_i & we_i & is_io;

  assign unused_ok = &{1'b0, addr_i[27:RAM_AW+2]};

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we && sel_i[b]) begin
        mem[widx][8*b +: 8] <= data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q <= 8'h00;
    end else if (io_we && off == IO_LED && sel_i[0]) begin
      led_q <= data_i[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
    end else if (io_we && off == IO_CYCLE && |sel_i) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign uart_start = io_we & (off == IO_UART_TX) & sel_i[0];

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk     (clk),
    .rst     (rst),
    .start_i (uart_start),
    .byte_i  (data_i[7:0]),
    .busy_o  (uart_busy),
    .tx_o    (uart_tx_o)
  );

  always_comb begin
    data_o = '0;
    if (ce_i && !we_i) begin
      if (is_ram) begin
        data_o = mem[widx];
      end else if (is_io) begin
        case (off)
          IO_LED:       data_o = {24'h0, led_q};
          IO_CYCLE:     data_o = cycle_q;
          IO_UART_STAT: data_o = {31'h0, uart_busy};
          default:      data_o = '0;
        endcase
      end
    end
  end

  assign led_o = led_q;

endmodule
